// File: rtl/mem_sync_pkg.sv
// Shared types and helpers for the simple-dual-port synchronous RAM.
package mem_sync_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/mem_sync_clr_seq.sv
// Zero-fill sequencer: walks every address once after reset or on a clr request.
module mem_sync_clr_seq
  import mem_sync_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic             busy,
  output logic             clr_we,
  output logic [CNT_W-1:0] clr_addr
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // busy comes straight from the state register so requests are gated by a flop
  assign busy     = (state_q == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/mem_sync_dp.sv
// Simple-dual-port synchronous RAM with byte enables, optional output register,
// selectable read-during-write behaviour and a hardware zero-fill sequencer.
module mem_sync_dp
  import mem_sync_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 2 ** ADDR_W,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                clr,
  output logic                busy
);

  localparam int              NB      = DATA_W / 8;
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_chk_data_w
    $error("mem_sync_dp: DATA_W must be a positive multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > 2 ** ADDR_W) begin : g_chk_depth
    $error("mem_sync_dp: DEPTH must be in 1 .. 2**ADDR_W");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic             clr_we;
  logic [IDX_W-1:0] clr_addr;

  mem_sync_clr_seq #(
    .DEPTH (DEPTH),
    .CNT_W (IDX_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic             wr_in_range, rd_in_range;
  logic             wr_acc, rd_acc, rdw_hit;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [DATA_W-1:0] rd_old, merged, rd_word;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_acc      = cs & wr_en & ~busy & wr_in_range;
  assign rd_acc      = cs & rd_en & ~busy;
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign rd_idx      = rd_addr[IDX_W-1:0];

  // Clear writes own the write port while busy; user writes are gated off then.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_old = mem[rd_idx];

  always_comb begin
    merged = rd_old;
    for (int unsigned i = 0; i < NB; i++) begin
      merged[8*i +: 8] = merge_byte(rd_old[8*i +: 8], wr_data[8*i +: 8], wr_be[i]);
    end
  end

  assign rdw_hit = (RDW_MODE == RDW_NEW) && wr_acc && (wr_addr == rd_addr);

  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = rdw_hit ? merged : rd_old;
  end

  logic [DATA_W-1:0] rd_q;
  logic              rd_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rd_n_ok(rst_n)) begin
      rd_q <= '0;
      rd_v <= 1'b0;
    end else begin
      rd_v <= rd_acc;
      if (rd_acc) rd_q <= rd_word;
    end
  end

  function automatic logic rd_n_ok(input logic r);
    return r;
  endfunction

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] out_q;
    logic              out_v;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
        out_v <= 1'b0;
      end else begin
        out_v <= rd_v;
        if (rd_v) out_q <= rd_q;
      end
    end

    assign rd_data  = out_q;
    assign rd_valid = out_v;
  end else begin : g_no_out_reg
    assign rd_data  = rd_q;
    assign rd_valid = rd_v;
  end

endmodule

// File: tb/tb_mem_sync_dp.sv
// Self-checking bench: two RAM configurations driven in lockstep against a word-level model.
module tb_mem_sync_dp;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int DEP = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0]    wr_be = '0;

  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b, busy_a, busy_b;

  always #5 clk = ~clk;

  // A: 1-cycle latency, old-data on collision.  B: output register, write-first.
  mem_sync_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .OUT_REG(0), .RDW_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .clr(clr), .busy(busy_a));

  mem_sync_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .OUT_REG(1), .RDW_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .clr(clr), .busy(busy_b));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

  // Model: memory contents, remaining clear cycles, and expected outputs per instance.
  logic [31:0] m_mem [DEP];
  int          m_left;
  logic [31:0] ea_data, eb_data, pend_data, old_w, res_b;
  logic        ea_valid, eb_valid, pend_valid, rd_ok, wr_ok;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_left = DEP;
      ea_data = '0; ea_valid = 1'b0;
      eb_data = '0; eb_valid = 1'b0;
      pend_data = '0; pend_valid = 1'b0;
    end else begin
      rd_ok = cs && rd_en && (m_left == 0);
      wr_ok = cs && wr_en && (m_left == 0);
      old_w = (rd_addr < DEP) ? m_mem[rd_addr[3:0]] : 32'h0;
      res_b = (rd_addr < DEP && wr_ok && wr_addr == rd_addr) ? bmerge(old_w, wr_data, wr_be) : old_w;
      eb_valid = pend_valid;
      if (pend_valid) eb_data = pend_data;
      pend_valid = rd_ok;
      if (rd_ok) pend_data = res_b;
      ea_valid = rd_ok;
      if (rd_ok) ea_data = old_w;
      if (wr_ok && wr_addr < DEP) m_mem[wr_addr[3:0]] = bmerge(m_mem[wr_addr[3:0]], wr_data, wr_be);
      if (m_left > 0) begin
        m_mem[DEP - m_left] = '0;
        m_left--;
      end else if (clr) begin
        m_left = DEP;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy_a", busy_a, m_left > 0);
    chk("busy_b", busy_b, m_left > 0);
    chk("valid_a", rd_valid_a, ea_valid);
    chk("data_a", rd_data_a, ea_data);
    chk("valid_b", rd_valid_b, eb_valid);
    chk("data_b", rd_data_b, eb_data);
  end

  task automatic step(input logic c, input logic we, input logic [AW-1:0] wa,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic re, input logic [AW-1:0] ra, input logic cl);
    cs = c; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra; clr = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    step(1'b1, 1'b1, AW'(a), d, be, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input int a);
    step(1'b1, 1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
  endtask

  // n0 = busy samples already counted; counts one sample per cycle busy is high.
  task automatic wait_clear(input string name, input int n0);
    int n = n0;
    while (busy_a && n < 40) begin
      idle();
      if (busy_a) n++;
    end
    chk(name, n, DEP);
  endtask

  task automatic read_all_zero(input string name);
    int va = 0, vb = 0;
    logic [31:0] or_a = '0, or_b = '0;
    for (int i = 0; i < DEP; i++) begin
      rd(i);
      va += int'(rd_valid_a); vb += int'(rd_valid_b);
      if (rd_valid_a) or_a |= rd_data_a;
      if (rd_valid_b) or_b |= rd_data_b;
    end
    repeat (2) begin
      idle();
      va += int'(rd_valid_a); vb += int'(rd_valid_b);
      if (rd_valid_b) or_b |= rd_data_b;
    end
    chk({name, "_cnt_a"}, va, DEP);
    chk({name, "_cnt_b"}, vb, DEP);
    chk({name, "_or_a"}, or_a, 32'h0);
    chk({name, "_or_b"}, or_b, 32'h0);
  endtask

  task automatic fill();
    for (int i = 0; i < DEP; i++) wr(i, 32'h01010101 * (i + 1), 4'hF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_a, 1'b1);
    chk("rst_valid_a", rd_valid_a, 1'b0);
    chk("rst_data_b", rd_data_b, 32'h0);
    rst_n = 1'b1;
    wait_clear("init_busy_cycles", 1);
    read_all_zero("init_read");

    // byte-enable merge
    wr(3, 32'hAABBCCDD, 4'hF);
    wr(3, 32'h11223344, 4'b0101);
    rd(3);
    chk("be_merge_a", rd_data_a, 32'hAA22CC44);
    idle();
    chk("be_merge_b", rd_data_b, 32'hAA22CC44);

    // read-during-write on the same address
    wr(7, 32'h12, 4'hF);
    step(1'b1, 1'b1, 5'd7, 32'h55, 4'hF, 1'b1, 5'd7, 1'b0);
    chk("rdw_old_a", rd_data_a, 32'h12);
    rd(7);
    chk("rdw_next_a", rd_data_a, 32'h55);
    chk("rdw_new_b", rd_data_b, 32'h55);
    wr(8, 32'hDEADBEEF, 4'hF);
    step(1'b1, 1'b1, 5'd8, 32'h00000011, 4'b0001, 1'b1, 5'd8, 1'b0);
    chk("rdw_part_a", rd_data_a, 32'hDEADBEEF);
    idle();
    chk("rdw_part_b", rd_data_b, 32'hDEADBE11);

    // output-register pipeline ordering
    wr(1, 32'h101, 4'hF);
    wr(2, 32'h202, 4'hF);
    rd(0);
    chk("pipe0_valid_b", rd_valid_b, 1'b0);
    rd(1);
    chk("pipe1_valid_b", rd_valid_b, 1'b1);
    chk("pipe1_data_b", rd_data_b, 32'h0);
    rd(2);
    chk("pipe2_data_b", rd_data_b, 32'h101);
    idle();
    chk("pipe3_valid_b", rd_valid_b, 1'b1);
    chk("pipe3_data_b", rd_data_b, 32'h202);
    idle();
    chk("pipe4_valid_b", rd_valid_b, 1'b0);

    // out-of-range, zero byte-enable, chip select low
    wr(20, 32'hFFFFFFFF, 4'hF);
    rd(20);
    chk("oor_valid_a", rd_valid_a, 1'b1);
    chk("oor_data_a", rd_data_a, 32'h0);
    rd(4);
    chk("oor_alias_a", rd_data_a, 32'h0);
    wr(3, 32'h99999999, 4'h0);
    rd(3);
    chk("be0_noop_a", rd_data_a, 32'hAA22CC44);
    step(1'b0, 1'b1, 5'd3, 32'h77777777, 4'hF, 1'b1, 5'd3, 1'b0);
    chk("cs_low_valid_a", rd_valid_a, 1'b0);
    rd(3);
    chk("cs_low_data_a", rd_data_a, 32'hAA22CC44);
    idle();

    // clr with requests during busy; a read issued with clr still completes
    fill();
    step(1'b1, 1'b0, '0, '0, '0, 1'b1, 5'd5, 1'b1);
    chk("clr_rd_a", rd_data_a, 32'h06060606);
    begin
      int n = 1;
      for (int i = 0; i < 6; i++) begin
        step(1'b1, 1'b1, AW'(i), 32'hFFFFFFFF, 4'hF, 1'b1, AW'(i), 1'b1);
        if (i == 0) chk("clr_rd_b", rd_data_b, 32'h06060606);
        if (busy_a) n++;
      end
      wait_clear("clr_busy_cycles", n);
    end
    read_all_zero("clr_read");

    // reset in the middle of a clear
    fill();
    rd(3);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    repeat (4) idle();
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", busy_a, 1'b1);
    chk("midrst_valid_a", rd_valid_a, 1'b0);
    chk("midrst_data_a", rd_data_a, 32'h0);
    chk("midrst_data_b", rd_data_b, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_clear("midrst_busy_cycles", 1);
    read_all_zero("midrst_read");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
